lsu_mem_port: RTL

- Load/store unit that sits downstream of the ALU, which supplies the effective address.
- Takes one load or store request at a time (RV32I funct3 encodings) and checks alignment.
- Drives a word-addressed data-memory port with a valid/ready request channel and a response channel.
- Returns a sign/zero-extended load result, or a completion/error status, to the pipeline.

---
 rtl/lsu_mem_port_if.sv | 26 ++
 rtl/lsu_mem_port.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port_if.sv
// Data-memory port between the load/store unit and a word-addressed memory.
//   mem_req_valid/mem_req_ready : request handshake (LSU -> memory)
//   mem_we, mem_addr, mem_be,
//   mem_wdata                   : request payload, held stable until accepted
//   mem_rsp_valid, mem_rdata    : read data / write acknowledge (memory -> LSU)
// master = LSU side, slave = memory side.
interface lsu_mem_port_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store unit: accepts one RV32I load/store at a time, checks funct3 and
// alignment, drives the data-memory port and returns a formatted result.
//   clk, rst_n            : clock, synchronous active-low reset
//   req_valid/req_ready   : pipeline request handshake (ready only in IDLE)
//   is_store, funct3,
//   addr, wdata           : request fields
//   resp_valid            : one-cycle completion pulse
//   resp_rdata            : formatted load data (0 for stores and errors)
//   resp_misaligned,
//   resp_fault            : misalignment / illegal funct3 or bus timeout
//   mem                   : data-memory port (master side)
module lsu_mem_port #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_fault,
  lsu_mem_port_if.master mem
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_next;
  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_mis;
  logic        r_fault;
  logic [31:0] r_cnt;

  logic        w_illegal;
  logic        w_misal;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  // Request classification on the live inputs (only used in IDLE).
  always_comb begin
    if (is_store) w_illegal = (funct3 > 3'd2);
    else          w_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    case (funct3[1:0])
      2'b01:   w_misal = addr[0];
      2'b10:   w_misal = (addr[1:0] != 2'b00);
      default: w_misal = 1'b0;
    endcase
  end

  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TIMEOUT_CYCLES - 1);

  // Store lane steering; loads read the whole word.
  always_comb begin
    w_be = 4'b1111;
    w_wd = '0;
    if (r_is_store) begin
      w_wd = r_wdata;
      case (r_funct3[1:0])
        2'b00: begin
          w_be = 4'b0001 << r_addr[1:0];
          w_wd = {4{r_wdata[7:0]}};
        end
        2'b01: begin
          w_be = r_addr[1] ? 4'b1100 : 4'b0011;
          w_wd = {2{r_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load extraction and sign/zero extension.
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = mem.mem_rdata[7:0];
      2'd1:    w_byte = mem.mem_rdata[15:8];
      2'd2:    w_byte = mem.mem_rdata[23:16];
      default: w_byte = mem.mem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_is_store <= 1'b0;
      r_funct3   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_mis      <= 1'b0;
      r_fault    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_is_store <= is_store;
          r_funct3   <= funct3;
          r_addr     <= addr;
          r_wdata    <= wdata;
          r_rdata    <= '0;
          r_fault    <= w_illegal;
          // Illegal funct3 masks any misalignment report.
          r_mis      <= !w_illegal && w_misal;
        end
        S_ISSUE: if (mem.mem_req_ready) r_cnt <= '0;
        S_WAIT: begin
          if (mem.mem_rsp_valid) begin
            if (!r_is_store) r_rdata <= w_load;
          end else if (w_timeout) begin
            r_fault <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next            = r_state;
    req_ready         = 1'b0;
    resp_valid        = 1'b0;
    resp_rdata        = '0;
    resp_misaligned   = 1'b0;
    resp_fault        = 1'b0;
    mem.mem_req_valid = 1'b0;
    mem.mem_we        = 1'b0;
    mem.mem_addr      = '0;
    mem.mem_be        = '0;
    mem.mem_wdata     = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = (w_illegal || w_misal) ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        mem.mem_req_valid = 1'b1;
        mem.mem_we        = r_is_store;
        mem.mem_addr      = {r_addr[31:2], 2'b00};
        mem.mem_be        = w_be;
        mem.mem_wdata     = w_wd;
        if (mem.mem_req_ready) w_next = S_WAIT;
      end
      S_WAIT: if (mem.mem_rsp_valid || w_timeout) w_next = S_RESP;
      S_RESP: begin
        resp_valid      = 1'b1;
        resp_rdata      = r_rdata;
        resp_misaligned = r_mis;
        resp_fault      = r_fault;
        w_next          = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
